// File: rtl/detector_host_link.sv
// detector_host_link: streams one frame of pixels into the face detector,
// then drains its result store as (x, y) coordinate pairs.
module detector_host_link #(
  parameter int FRAME_WIDTH  = 800,
  parameter int FRAME_HEIGHT = 600,
  parameter int PIXEL_WIDTH  = 16,
  parameter int RESULT_WIDTH = 12,
  parameter int ACK_TIMEOUT  = 1023
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    pix_in_valid,
  input  logic [PIXEL_WIDTH-1:0]  pix_in_data,
  output logic                    pix_in_ready,
  output logic [PIXEL_WIDTH-1:0]  det_pixel,
  output logic                    det_recieve_pixel,
  input  logic                    det_ready_recieve_pixel,
  input  logic                    det_recieve_pixel_end,
  output logic                    det_trig_send_result,
  input  logic                    det_ready_send_result,
  input  logic [RESULT_WIDTH-1:0] det_result_data,
  input  logic                    det_result_end,
  output logic                    det_result_sent,
  output logic                    res_valid,
  output logic [RESULT_WIDTH-1:0] res_x,
  output logic [RESULT_WIDTH-1:0] res_y,
  input  logic                    res_ready,
  output logic                    busy,
  output logic                    frame_done,
  output logic                    error
);
  localparam int TOTAL = FRAME_WIDTH * FRAME_HEIGHT;
  localparam int CW    = $clog2(TOTAL + 1);
  localparam int TW    = $clog2(ACK_TIMEOUT + 1);
  typedef enum logic [3:0] {
    IDLE, FETCH, WAIT_RDY, WAIT_ACK, RES_CHECK, RES_WAIT, RES_TAKE, RES_OUT, DONE
  } state_t;
  state_t                  r_state, w_next;
  logic [CW-1:0]           r_cnt;
  logic [TW-1:0]           r_wait;
  logic                    r_half;
  logic [PIXEL_WIDTH-1:0]  r_pix;
  logic [RESULT_WIDTH-1:0] r_x, r_y;
  logic                    r_strobe, r_trig, r_error;
  logic                    w_stall, w_timeout, w_odd;
  always_comb begin
    w_next    = r_state;
    w_stall   = 1'b0;
    w_timeout = 1'b0;
    case (r_state)
      IDLE:      w_next = start ? FETCH : IDLE;
      FETCH:     w_next = pix_in_valid ? WAIT_RDY : FETCH;
      WAIT_RDY: begin
        w_stall = !det_ready_recieve_pixel;
        w_next  = det_ready_recieve_pixel ? WAIT_ACK : WAIT_RDY;
      end
      WAIT_ACK: begin
        w_stall = !det_recieve_pixel_end;
        w_next  = !det_recieve_pixel_end ? WAIT_ACK :
                  (r_cnt == CW'(TOTAL - 1)) ? RES_CHECK : FETCH;
      end
      RES_CHECK: w_next = det_result_end ? DONE : RES_WAIT;
      RES_WAIT: begin
        w_stall = !det_ready_send_result;
        w_next  = det_ready_send_result ? RES_TAKE : RES_WAIT;
      end
      RES_TAKE:  w_next = r_half ? RES_CHECK : RES_OUT;
      RES_OUT:   w_next = res_ready ? RES_CHECK : RES_OUT;
      DONE:      w_next = IDLE;
      default:   w_next = IDLE;
    endcase
    // backpressure states never stall-count, so only detector waits can expire
    w_timeout = w_stall && (r_wait == TW'(ACK_TIMEOUT - 1));
    if (w_timeout) w_next = DONE;
  end
  assign w_odd = (r_state == RES_CHECK) && det_result_end && r_half;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_wait   <= '0;
      r_half   <= 1'b0;
      r_pix    <= '0;
      r_x      <= '0;
      r_y      <= '0;
      r_strobe <= 1'b0;
      r_trig   <= 1'b0;
      r_error  <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_strobe <= (r_state == WAIT_RDY) && (w_next == WAIT_ACK);
      r_trig   <= (r_state == RES_CHECK) && (w_next == RES_WAIT);
      r_wait   <= (w_next != r_state) ? '0 : r_wait + TW'(w_stall);
      if (r_state == FETCH && pix_in_valid) r_pix <= pix_in_data;
      if (r_state == WAIT_ACK && det_recieve_pixel_end) r_cnt <= r_cnt + CW'(1);
      if (r_state == RES_WAIT && det_ready_send_result) begin
        if (r_half) r_y <= det_result_data;
        else r_x <= det_result_data;
        r_half <= !r_half;
      end
      if (w_odd) r_half <= 1'b0;
      if (w_timeout || w_odd) r_error <= 1'b1;
      if (r_state == IDLE && start) begin
        r_cnt   <= '0;
        r_half  <= 1'b0;
        r_error <= 1'b0;
      end
    end
  end
  assign pix_in_ready         = (r_state == FETCH);
  assign det_pixel            = r_pix;
  assign det_recieve_pixel    = r_strobe;
  assign det_trig_send_result = r_trig;
  assign det_result_sent      = (r_state == RES_TAKE);
  assign res_valid            = (r_state == RES_OUT);
  assign res_x                = r_x;
  assign res_y                = r_y;
  assign busy                 = (r_state != IDLE);
  assign frame_done           = (r_state == DONE);
  assign error                = r_error;
endmodule
